// File: rtl/nios_spi_pkg.sv
// nios_spi_pkg: register map, CTRL/STATUS bit positions and FSM encoding for nios_spi_cmd_master
package nios_spi_pkg;
    localparam logic [2:0] REG_ADDR   = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_WDATA  = 3'd3;
    localparam logic [2:0] REG_RDATA  = 3'd4;
    localparam int CTRL_GO      = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_LEN_LSB = 8;
    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_ERR       = 2;
    localparam int ST_WLVL_LSB  = 4;
    localparam int ST_RLVL_LSB  = 12;
    localparam int CMD_WRITE_BIT = 2;
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HDR, S_WPAY, S_RLEN, S_COLLECT, S_TAIL, S_GAP
    } state_t;
endpackage

// File: rtl/nios_spi_cmd_master_cmd_byte_fifo.sv
// cmd_byte_fifo: synchronous 8-bit FIFO with level output; push when full is dropped unless a pop
// frees a slot in the same cycle, pop when empty is ignored.
// Ports: clk, rst (async active-low), push/din, pop/dout (head byte), full, empty, level.
module cmd_byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    // DEPTH is a power of two, so the level MSB alone means full
    assign full = level[AW];
    assign empty = level == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rp];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/nios_spi_cmd_master.sv
// nios_spi_cmd_master: Avalon-MM slave that frames SPI transactions into the SPI write FIFO,
// drives the active-low frame select nios_cs and drains the SPI read FIFO into a CPU buffer.
// Ports: clk, rst (async active-low); avs_* register bus (no waitrequest, readdata one cycle
// after avs_read); nios_cs; wr_fifo_valid/data/ready push side; rd_fifo_valid/data/ready pop
// side; irq = done & irq_en.
// Optional: define SPI_RD_TIMEOUT_EN to abort COLLECT after TIMEOUT_CYCLES idle cycles.
module nios_spi_cmd_master
    import nios_spi_pkg::*;
#(
    parameter int BUF_DEPTH    = 64,
    parameter int BYTE_GAP     = 100,
    parameter int SETUP_CYCLES = 8,
    parameter int TAIL_CYCLES  = 120,
    parameter int CS_GAP       = 16
`ifdef SPI_RD_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        nios_cs,
    output logic        wr_fifo_valid,
    output logic [31:0] wr_fifo_data,
    input  logic        wr_fifo_ready,
    input  logic        rd_fifo_valid,
    input  logic [7:0]  rd_fifo_data,
    output logic        rd_fifo_ready,
    output logic        irq
);
    localparam int LW = $clog2(BUF_DEPTH) + 1;
    state_t state;
    logic [15:0] addr_q, f_addr, timer, pace;
    logic [7:0] len_q, f_len, bcnt, go_len, hdr_byte, tx_byte, w_head, r_head;
    logic dir_q, f_dir, irq_en, done, err;
    logic [LW-1:0] w_level, r_level;
    logic w_full, w_empty, r_full, r_empty, w_push, w_pop, r_push, r_pop;
    logic tx_go, go, go_bad, unused_ok;
    logic [31:0] status, ctrl, rd_mux;
`ifdef SPI_RD_TIMEOUT_EN
    logic [15:0] to_cnt;
`endif

    assign unused_ok = ^avs_writedata[31:16];
    assign irq = done & irq_en;
    assign w_push = avs_write && avs_address == REG_WDATA;
    assign r_pop = avs_read && avs_address == REG_RDATA;
    assign rd_fifo_ready = state == S_COLLECT && rd_fifo_valid && !r_full;
    assign r_push = rd_fifo_ready;
    // one paced push per BYTE_GAP window, only while the SPI write FIFO has room
    assign tx_go = (state == S_HDR || state == S_RLEN || (state == S_WPAY && !w_empty))
                   && pace == '0 && wr_fifo_ready;
    assign w_pop = state == S_WPAY && tx_go;
    assign hdr_byte = bcnt == 8'd0 ? f_addr[15:8] : bcnt == 8'd1 ? f_addr[7:0] : 8'(f_dir) << CMD_WRITE_BIT;
    assign tx_byte = state == S_HDR ? hdr_byte : state == S_WPAY ? w_head : f_len;
    assign go_len = avs_writedata[CTRL_LEN_LSB +: 8];
    assign go = avs_write && avs_address == REG_CTRL && avs_writedata[CTRL_GO] && state == S_IDLE;
    assign go_bad = go_len == '0 || (avs_writedata[CTRL_DIR] ? int'(w_level) < int'(go_len)
                                                             : BUF_DEPTH - int'(r_level) < int'(go_len));

    always_comb begin
        status = '0;
        status[ST_BUSY] = state != S_IDLE;
        status[ST_DONE] = done;
        status[ST_ERR] = err;
        status[ST_WLVL_LSB +: 8] = 8'(w_level);
        status[ST_RLVL_LSB +: 8] = 8'(r_level);
        ctrl = '0;
        ctrl[CTRL_DIR] = dir_q;
        ctrl[CTRL_IRQ_EN] = irq_en;
        ctrl[CTRL_LEN_LSB +: 8] = len_q;
        rd_mux = avs_address == REG_ADDR ? {16'h0, addr_q} :
                 avs_address == REG_CTRL ? ctrl :
                 avs_address == REG_STATUS ? status :
                 avs_address == REG_RDATA ? {24'h0, r_empty ? 8'h00 : r_head} : 32'h0;
    end

    cmd_byte_fifo #(.DEPTH(BUF_DEPTH)) u_wbuf (
        .clk(clk), .rst(rst), .push(w_push), .din(avs_writedata[7:0]), .pop(w_pop),
        .dout(w_head), .full(w_full), .empty(w_empty), .level(w_level)
    );
    cmd_byte_fifo #(.DEPTH(BUF_DEPTH)) u_rbuf (
        .clk(clk), .rst(rst), .push(r_push), .din(rd_fifo_data), .pop(r_pop),
        .dout(r_head), .full(r_full), .empty(r_empty), .level(r_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            nios_cs <= 1'b1;
            wr_fifo_valid <= 1'b0;
            wr_fifo_data <= '0;
            avs_readdata <= '0;
            addr_q <= '0;
            f_addr <= '0;
            len_q <= '0;
            f_len <= '0;
            bcnt <= '0;
            dir_q <= 1'b0;
            f_dir <= 1'b0;
            irq_en <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            timer <= '0;
            pace <= '0;
`ifdef SPI_RD_TIMEOUT_EN
            to_cnt <= '0;
`endif
        end else begin
            wr_fifo_valid <= 1'b0;
            if (avs_read) avs_readdata <= rd_mux;
            if (pace != '0) pace <= pace - 16'd1;
            if (avs_write && avs_address == REG_ADDR) addr_q <= avs_writedata[15:0];
            if (avs_write && avs_address == REG_CTRL) begin
                len_q <= go_len;
                dir_q <= avs_writedata[CTRL_DIR];
                irq_en <= avs_writedata[CTRL_IRQ_EN];
            end
            // status clears come first so that same-cycle sets below win
            if (avs_write && avs_address == REG_STATUS) begin
                done <= 1'b0;
                err <= 1'b0;
            end
            if (w_push && w_full && !w_pop) err <= 1'b1;
            if (tx_go) begin
                wr_fifo_valid <= 1'b1;
                wr_fifo_data <= {24'h0, tx_byte};
                pace <= 16'(BYTE_GAP - 1);
                bcnt <= bcnt + 8'd1;
            end
            case (state)
                S_IDLE: if (go) begin
                    if (go_bad) err <= 1'b1;
                    else begin
                        state <= S_SETUP;
                        nios_cs <= 1'b0;
                        timer <= 16'(SETUP_CYCLES - 1);
                        pace <= '0;
                        bcnt <= '0;
                        f_addr <= addr_q;
                        f_len <= go_len;
                        f_dir <= avs_writedata[CTRL_DIR];
                    end
                end
                S_SETUP: if (timer == '0) state <= S_HDR; else timer <= timer - 16'd1;
                S_HDR: if (tx_go && bcnt == 8'd2) begin
                    bcnt <= '0;
                    state <= f_dir ? S_WPAY : S_RLEN;
                end
                S_WPAY: if (tx_go && bcnt == f_len - 8'd1) begin
                    state <= S_TAIL;
                    timer <= 16'(TAIL_CYCLES - 1);
                end
                S_RLEN: if (tx_go) begin
                    bcnt <= '0;
                    state <= S_COLLECT;
`ifdef SPI_RD_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                S_COLLECT: begin
                    if (r_push) begin
                        bcnt <= bcnt + 8'd1;
                        if (bcnt == f_len - 8'd1) begin
                            state <= S_TAIL;
                            timer <= 16'(TAIL_CYCLES - 1);
                        end
                    end
`ifdef SPI_RD_TIMEOUT_EN
                    to_cnt <= r_push ? '0 : to_cnt + 16'd1;
                    if (!r_push && to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        err <= 1'b1;
                        state <= S_TAIL;
                        timer <= 16'(TAIL_CYCLES - 1);
                    end
`endif
                end
                S_TAIL: if (timer == '0) begin
                    state <= S_GAP;
                    nios_cs <= 1'b1;
                    timer <= 16'(CS_GAP - 1);
                end else timer <= timer - 16'd1;
                S_GAP: if (timer == '0) begin
                    state <= S_IDLE;
                    done <= 1'b1;
                end else timer <= timer - 16'd1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nios_spi_cmd_master.sv
// tb_nios_spi_cmd_master: scoreboard bench for nios_spi_cmd_master (SPI_RD_TIMEOUT_EN adds test_timeout)
`timescale 1ns/1ps
module tb_nios_spi_cmd_master;
    import nios_spi_pkg::*;
    localparam int BUF_DEPTH = 64, BYTE_GAP = 20, SETUP_CYCLES = 8, TAIL_CYCLES = 30, CS_GAP = 16;
`ifdef SPI_RD_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 100;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] avs_address = '0;
    logic avs_write = 1'b0, avs_read = 1'b0;
    logic [31:0] avs_writedata = '0, avs_readdata, wr_fifo_data;
    logic nios_cs, wr_fifo_valid, rd_fifo_ready, irq;
    logic wr_fifo_ready = 1'b1, rd_fifo_valid = 1'b0;
    logic [7:0] rd_fifo_data = '0;
    int n_tests = 0, n_fail = 0, cyc = 0, pushes = 0, last_push = -1;
    logic [7:0] exp_wr[$], exp_rd[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    nios_spi_cmd_master #(
        .BUF_DEPTH(BUF_DEPTH), .BYTE_GAP(BYTE_GAP), .SETUP_CYCLES(SETUP_CYCLES),
        .TAIL_CYCLES(TAIL_CYCLES), .CS_GAP(CS_GAP)
`ifdef SPI_RD_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) dut (
        .clk(clk), .rst(rst), .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .nios_cs(nios_cs), .wr_fifo_valid(wr_fifo_valid), .wr_fifo_data(wr_fifo_data),
        .wr_fifo_ready(wr_fifo_ready), .rd_fifo_valid(rd_fifo_valid), .rd_fifo_data(rd_fifo_data),
        .rd_fifo_ready(rd_fifo_ready), .irq(irq)
    );

    // scoreboard side: every push must match the next expected byte, inside a frame, paced
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (rst && wr_fifo_valid) begin
            pushes++;
            n_tests++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_push got %h exp none", wr_fifo_data);
            end else begin
                e = exp_wr.pop_front();
                if (wr_fifo_data !== {24'h0, e}) begin
                    n_fail++;
                    $display("FAIL push_byte got %h exp %h", wr_fifo_data, {24'h0, e});
                end
            end
            n_tests++;
            if (nios_cs !== 1'b0) begin
                n_fail++;
                $display("FAIL push_cs_low got %b exp 0", nios_cs);
            end
            if (last_push >= 0) begin
                n_tests++;
                if (cyc - last_push < BYTE_GAP) begin
                    n_fail++;
                    $display("FAIL push_gap got %0d exp >= %0d", cyc - last_push, BYTE_GAP);
                end
            end
            last_push = cyc;
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    function automatic logic [31:0] ctrl_word(input logic [7:0] len, input logic dir, input logic ie, input logic go);
        return {16'h0, len, 5'h0, ie, dir, go};
    endfunction

    task automatic wait_irq(input int budget, input string name);
        int i = 0;
        while (irq !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_irq_timeout got irq=%b exp 1", name, irq);
        end
    endtask

    task automatic feed(input logic [7:0] b);
        int i = 0;
        @(negedge clk);
        rd_fifo_valid = 1'b1;
        rd_fifo_data = b;
        #1;
        while (rd_fifo_ready !== 1'b1 && i < 2000) begin
            @(negedge clk);
            #1;
            i++;
        end
        n_tests++;
        if (rd_fifo_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL feed_pop got ready=%b exp 1", rd_fifo_ready);
        end else exp_rd.push_back(b);
        @(negedge clk);
        rd_fifo_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (nios_cs !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cs got %b exp 1", nios_cs);
        end
        n_tests++;
        if ({wr_fifo_valid, wr_fifo_data, rd_fifo_ready, avs_readdata, irq} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b %h %b %h %b exp all zero", wr_fifo_valid, wr_fifo_data, rd_fifo_ready, avs_readdata, irq);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status got %h exp %h", d, 32'h0);
        end
        cpu_read(REG_RDATA, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata_empty got %h exp %h", d, 32'h0);
        end
    endtask

    task automatic test_write_frame;
        logic [31:0] d;
        cpu_write(REG_WDATA, 32'hA1);
        cpu_write(REG_WDATA, 32'hB2);
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h20) begin
            n_fail++;
            $display("FAIL wr_wlevel got %h exp %h", d, 32'h20);
        end
        cpu_write(REG_ADDR, 32'h1234);
        cpu_read(REG_ADDR, d);
        n_tests++;
        if (d !== 32'h1234) begin
            n_fail++;
            $display("FAIL wr_addr_rb got %h exp %h", d, 32'h1234);
        end
        exp_wr = '{8'h12, 8'h34, 8'h04, 8'hA1, 8'hB2};
        cpu_write(REG_CTRL, ctrl_word(8'd2, 1'b1, 1'b1, 1'b1));
        n_tests++;
        if (nios_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_cs_fall got %b exp 0", nios_cs);
        end
        cpu_read(REG_CTRL, d);
        n_tests++;
        if (d !== 32'h0206) begin
            n_fail++;
            $display("FAIL wr_ctrl_rb got %h exp %h", d, 32'h0206);
        end
        wait_irq(2000, "wr");
        n_tests++;
        if (exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL wr_drained got %0d left exp 0", exp_wr.size());
        end
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL wr_status got %h exp %h", d, 32'h2);
        end
        n_tests++;
        if (nios_cs !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_cs_rise got %b exp 1", nios_cs);
        end
        cpu_write(REG_STATUS, 32'h0);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_irq_clear got %b exp 0", irq);
        end
    endtask

    task automatic test_read_frame;
        logic [31:0] d;
        logic [7:0] e;
        cpu_write(REG_ADDR, 32'h0010);
        exp_wr = '{8'h00, 8'h10, 8'h00, 8'h03};
        cpu_write(REG_CTRL, ctrl_word(8'd3, 1'b0, 1'b1, 1'b1));
        feed(8'h55);
        feed(8'h66);
        feed(8'h77);
        wait_irq(2000, "rd");
        n_tests++;
        if (exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL rd_drained got %0d left exp 0", exp_wr.size());
        end
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h3002) begin
            n_fail++;
            $display("FAIL rd_status got %h exp %h", d, 32'h3002);
        end
        repeat (3) begin
            cpu_read(REG_RDATA, d);
            e = exp_rd.size() != 0 ? exp_rd.pop_front() : 8'h00;
            n_tests++;
            if (d !== {24'h0, e}) begin
                n_fail++;
                $display("FAIL rd_rdata got %h exp %h", d, {24'h0, e});
            end
        end
        cpu_read(REG_RDATA, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_rdata_empty got %h exp %h", d, 32'h0);
        end
        cpu_write(REG_STATUS, 32'h0);
    endtask

    task automatic test_error_gating;
        logic [31:0] d;
        logic cs_hi;
        int p0;
        cpu_write(REG_WDATA, 32'hC3);
        cpu_write(REG_WDATA, 32'hD4);
        rd_fifo_valid = 1'b1;
        rd_fifo_data = 8'hEE;
        #1;
        n_tests++;
        if (rd_fifo_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_stray_ready got %b exp 0", rd_fifo_ready);
        end
        rd_fifo_valid = 1'b0;
        p0 = pushes;
        cpu_write(REG_CTRL, ctrl_word(8'd4, 1'b1, 1'b0, 1'b1));
        cs_hi = 1'b1;
        repeat (20) begin
            @(negedge clk);
            cs_hi &= nios_cs;
        end
        n_tests++;
        if (cs_hi !== 1'b1 || pushes != p0) begin
            n_fail++;
            $display("FAIL err_short_wbuf got cs_hi=%b pushes=%0d exp 1 %0d", cs_hi, pushes, p0);
        end
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h24) begin
            n_fail++;
            $display("FAIL err_short_status got %h exp %h", d, 32'h24);
        end
        cpu_write(REG_STATUS, 32'h0);
        cpu_write(REG_CTRL, ctrl_word(8'd0, 1'b1, 1'b0, 1'b1));
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h24) begin
            n_fail++;
            $display("FAIL err_len0_status got %h exp %h", d, 32'h24);
        end
        cpu_write(REG_STATUS, 32'h0);
        cpu_write(REG_CTRL, ctrl_word(8'd255, 1'b0, 1'b0, 1'b1));
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h24 || nios_cs !== 1'b1) begin
            n_fail++;
            $display("FAIL err_rbuf_free got %h cs=%b exp %h cs=1", d, nios_cs, 32'h24);
        end
        cpu_write(REG_STATUS, 32'h0);
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        int p0, p1, i;
        cpu_write(REG_WDATA, 32'hE5);
        cpu_write(REG_ADDR, 32'hBEEF);
        exp_wr = '{8'hBE, 8'hEF, 8'h04, 8'hC3, 8'hD4, 8'hE5};
        p0 = pushes;
        cpu_write(REG_CTRL, ctrl_word(8'd3, 1'b1, 1'b1, 1'b1));
        i = 0;
        while (pushes < p0 + 1 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        n_tests++;
        if (pushes != p0 + 1) begin
            n_fail++;
            $display("FAIL bp_first_push got %0d exp %0d", pushes - p0, 1);
        end
        wr_fifo_ready = 1'b0;
        p1 = pushes;
        repeat (500) @(negedge clk);
        n_tests++;
        if (pushes != p1 || nios_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold got pushes=%0d cs=%b exp %0d cs=0", pushes, nios_cs, p1);
        end
        wr_fifo_ready = 1'b1;
        wait_irq(3000, "bp");
        n_tests++;
        if (exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drained got %0d left exp 0", exp_wr.size());
        end
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL bp_status got %h exp %h", d, 32'h2);
        end
        cpu_write(REG_STATUS, 32'h0);
    endtask

    task automatic test_reset_mid_wpay;
        logic [31:0] d;
        int p0, i;
        cpu_write(REG_WDATA, 32'h11);
        cpu_write(REG_WDATA, 32'h22);
        cpu_write(REG_WDATA, 32'h33);
        cpu_write(REG_ADDR, 32'h0000);
        exp_wr = '{8'h00, 8'h00, 8'h04, 8'h11};
        p0 = pushes;
        cpu_write(REG_CTRL, ctrl_word(8'd3, 1'b1, 1'b1, 1'b1));
        i = 0;
        while (pushes < p0 + 4 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        n_tests++;
        if (pushes != p0 + 4) begin
            n_fail++;
            $display("FAIL rst_reach_wpay got %0d exp %0d", pushes - p0, 4);
        end
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (nios_cs !== 1'b1 || {wr_fifo_valid, wr_fifo_data, rd_fifo_ready, avs_readdata, irq} !== 67'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got cs=%b %b %h %b %h %b exp cs=1 rest zero", nios_cs, wr_fifo_valid, wr_fifo_data, rd_fifo_ready, avs_readdata, irq);
        end
        exp_wr.delete();
        last_push = -1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_status got %h exp %h", d, 32'h0);
        end
        cpu_write(REG_WDATA, 32'h5A);
        cpu_write(REG_ADDR, 32'h0102);
        exp_wr = '{8'h01, 8'h02, 8'h04, 8'h5A};
        cpu_write(REG_CTRL, ctrl_word(8'd1, 1'b1, 1'b1, 1'b1));
        wait_irq(2000, "rst_rerun");
        n_tests++;
        if (exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL rst_rerun_drained got %0d left exp 0", exp_wr.size());
        end
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL rst_rerun_status got %h exp %h", d, 32'h2);
        end
        cpu_write(REG_STATUS, 32'h0);
    endtask

`ifdef SPI_RD_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] d;
        cpu_write(REG_ADDR, 32'h0020);
        exp_wr = '{8'h00, 8'h20, 8'h00, 8'h02};
        cpu_write(REG_CTRL, ctrl_word(8'd2, 1'b0, 1'b1, 1'b1));
        feed(8'h99);
        wait_irq(2000, "to");
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h1006 || exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL to_status got %h left=%0d exp %h left=0", d, exp_wr.size(), 32'h1006);
        end
        cpu_read(REG_RDATA, d);
        n_tests++;
        if (d !== 32'h99) begin
            n_fail++;
            $display("FAIL to_rdata got %h exp %h", d, 32'h99);
        end
        cpu_write(REG_STATUS, 32'h0);
    endtask
`endif

    task automatic test_wbuf_full;
        logic [31:0] d;
        for (int i = 0; i < BUF_DEPTH; i++) cpu_write(REG_WDATA, 32'(i));
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h400) begin
            n_fail++;
            $display("FAIL full_level got %h exp %h", d, 32'h400);
        end
        cpu_write(REG_WDATA, 32'hFF);
        cpu_read(REG_STATUS, d);
        n_tests++;
        if (d !== 32'h404) begin
            n_fail++;
            $display("FAIL full_overflow_err got %h exp %h", d, 32'h404);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_frame();
        test_read_frame();
        test_error_gating();
        test_backpressure();
        test_reset_mid_wpay();
`ifdef SPI_RD_TIMEOUT_EN
        test_timeout();
`endif
        test_wbuf_full();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nios_spi_cmd_master.md
Name: nios_spi_cmd_master

Overview:
- Avalon-MM slave for the Nios CPU that builds SPI transaction frames and pushes them, one byte per 32-bit word, into the SPI write FIFO.
- Drives the active-low frame select nios_cs that gates the downstream FIFO-to-SPI bridge.
- Drains that bridge's read FIFO into a local buffer the CPU pops.
- Sits between the Nios register bus and the SPI FIFO pair.

Parameters:
- BUF_DEPTH, 64: depth of the local write and read byte buffers (power of two, ≥ 256 not required).
- BYTE_GAP, 100: clk cycles between consecutive pushes to the write FIFO; sized to be at least one SPI byte time.
- SETUP_CYCLES, 8: cycles from nios_cs falling to the first byte push.
- TAIL_CYCLES, 120: cycles after the last pushed byte before nios_cs rises.
- CS_GAP, 16: minimum nios_cs high cycles between frames.
- TIMEOUT_CYCLES, 65535: read collect timeout (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- avs_address  in  3  register word address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, registered
- nios_cs  out  1  frame select, active low
- wr_fifo_valid  out  1  push strobe to the SPI write FIFO
- wr_fifo_data  out  32  byte in [7:0]; [31:8] = 0
- wr_fifo_ready  in  1  SPI write FIFO not full
- rd_fifo_valid  in  1  SPI read FIFO has data
- rd_fifo_data  in  8  received SPI byte
- rd_fifo_ready  out  1  pop strobe to the SPI read FIFO
- irq  out  1  level interrupt = done & irq_en

Behaviour:
- Reset: rst is asynchronous and active low; clock is clk. At reset: nios_cs=1, wr_fifo_valid=0, wr_fifo_data=0, rd_fifo_ready=0, avs_readdata=0, irq=0. All registers clear, both buffers empty, FSM in IDLE.
- Register map:
  - 0 ADDR: RW, [15:0].
  - 1 CTRL: RW. [0] GO, write-1 self-clearing, reads 0. [1] DIR, 1=write, 0=read. [2] irq_en. [15:8] LEN.
  - 2 STATUS: RO. [0] busy. [1] done, sticky. [2] err, sticky. [11:4] wbuf level. [19:12] rbuf level. Writing any value to STATUS clears done and err.
  - 3 WDATA: WO. Pushes [7:0] into wbuf. Push when full is dropped and sets err.
  - 4 RDATA: RO. Pops rbuf; readdata [7:0] = head byte. Pop when empty returns 0.
- Avalon timing: no waitrequest; readdata is valid one cycle after avs_read.
- GO acceptance checks:
  - GO while busy is ignored.
  - LEN=0 sets err; no frame.
  - DIR=1 with wbuf level < LEN sets err; no frame.
  - DIR=0 with rbuf free < LEN sets err; no frame.
- Frame bytes, in order: ADDR[15:8], ADDR[7:0], CONTROL = {5'b0, DIR, 2'b00} (bit2 = write). Then:
  - write: LEN payload bytes popped from wbuf;
  - read: one length byte = LEN.
- FSM states:
  - IDLE: valid GO → SETUP, nios_cs=0, busy=1.
  - SETUP: after SETUP_CYCLES → HDR.
  - HDR: push 3 header bytes → WPAY (DIR=1) or RLEN (DIR=0).
  - WPAY: push LEN bytes → TAIL.
  - RLEN: push length byte → COLLECT.
  - COLLECT: rd_fifo_ready = rd_fifo_valid; each popped byte is written to rbuf. After LEN bytes → TAIL.
  - TAIL: after TAIL_CYCLES → GAP, nios_cs=1.
  - GAP: after CS_GAP cycles → IDLE, busy=0, done=1.
- Push rule: wr_fifo_valid is a single-cycle pulse. It is issued only when wr_fifo_ready=1 and the pacing counter has expired; the counter reloads to BYTE_GAP on each push. If ready is low, the push waits; bytes are never dropped.
- Counters: byte counter is 8 bits and compares to LEN; there is no wrap since LEN ≤ 255.
- Any rbuf data stray outside COLLECT: rd_fifo_ready=0.
- Simultaneous events: a CPU RDATA pop and a COLLECT write in the same cycle both take effect and the level is unchanged. The same holds for WDATA push against a WPAY pop.
- Reset mid-frame: nios_cs rises immediately (asynchronously); the partial frame is abandoned.

Optional Feature:
- Macro: SPI_RD_TIMEOUT_EN.
- Defined: a 16-bit counter runs in COLLECT and clears on each popped byte. When it reaches TIMEOUT_CYCLES, err=1 and the FSM goes to TAIL; done is still set at GAP exit.
- Undefined: COLLECT waits indefinitely and no counter is synthesised.

Decomposition:
- Package nios_spi_pkg:
  - register offsets;
  - CTRL and STATUS bit positions;
  - FSM state encoding;
  - CONTROL byte write bit (2).
- Sub-module cmd_byte_fifo: synchronous 8-bit FIFO with level output, parameter DEPTH. Instantiated twice, for wbuf and rbuf.

Test Plan:
- Write frame: WDATA 0xA1, 0xB2; ADDR=0x1234; CTRL LEN=2, DIR=1, GO → wr_fifo bytes 0x12, 0x34, 0x04, 0xA1, 0xB2, each ≥ BYTE_GAP apart; nios_cs low throughout; done=1; wbuf level=0.
- Read frame: ADDR=0x0010, LEN=3, DIR=0, GO; model feeds 0x55, 0x66, 0x77 on rd_fifo → pushed bytes 0x00, 0x10, 0x00, 0x03; three RDATA reads return 0x55, 0x66, 0x77.
- Error gating: LEN=4, DIR=1 with wbuf level 2 → err=1, nios_cs stays 1, no push. LEN=0 → err=1.
- Backpressure: hold wr_fifo_ready=0 for 500 cycles mid-header → no byte lost; order preserved; frame completes.
- Reset mid-WPAY → nios_cs=1 and all outputs at reset values in the same cycle; a new GO after reset runs cleanly.
- SPI_RD_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, read LEN=2, only one byte supplied → err=1 and done=1; rbuf level=1.
